// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg -- shared definitions for the sequenced ALU front end.
//   Opcode/funct encodings of the supported instruction subset, the ALU
//   control encoding driven on alu_f, the sequencer state encoding, and
//   the operand-B select / immediate extension helpers used by decode.
package alu_seq_pkg;

   // Primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   // R-type function codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU control word as understood by the external ALU
   typedef enum logic [2:0] {
      ALU_AND = 3'b000,
      ALU_OR  = 3'b001,
      ALU_ADD = 3'b010,
      ALU_SUB = 3'b110,
      ALU_SLT = 3'b111
   } alu_ctl_e;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Operand B source
   typedef enum logic {
      BSEL_RT  = 1'b0,
      BSEL_IMM = 1'b1
   } bsel_e;

   // Immediate extension mode
   typedef enum logic {
      EXT_ZERO = 1'b0,
      EXT_SIGN = 1'b1
   } ext_e;

   // Widen a 16-bit immediate to 32 bits according to the extension mode
   function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_e mode);
      logic [31:0] res;
      if (mode == EXT_SIGN) begin
         res = {{16{imm[15]}}, imm};
      end else begin
         res = {16'h0000, imm};
      end
      return res;
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode -- purely combinational instruction decode.
//   opcode, funct : instruction fields
//   f             : ALU control word
//   b_sel         : operand B from rt or from the extended immediate
//   ext_mode      : sign or zero extension of the immediate
//   is_beq        : branch-equal, result zero flag becomes branch_taken
//   illegal       : opcode/funct outside the supported subset
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output alu_ctl_e   f,
   output bsel_e      b_sel,
   output ext_e       ext_mode,
   output logic       is_beq,
   output logic       illegal
);

   // Map opcode/funct onto ALU control, operand-B source and flags
   always_comb begin
      f        = ALU_AND;
      b_sel    = BSEL_RT;
      ext_mode = EXT_ZERO;
      is_beq   = 1'b0;
      illegal  = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD:  f = ALU_ADD;
               FN_SUB:  f = ALU_SUB;
               FN_AND:  f = ALU_AND;
               FN_OR:   f = ALU_OR;
               FN_SLT:  f = ALU_SLT;
               default: illegal = 1'b1;
            endcase
         end
         OP_ADDI: begin
            f        = ALU_ADD;
            b_sel    = BSEL_IMM;
            ext_mode = EXT_SIGN;
         end
         OP_SLTI: begin
            f        = ALU_SLT;
            b_sel    = BSEL_IMM;
            ext_mode = EXT_SIGN;
         end
         OP_ANDI: begin
            f        = ALU_AND;
            b_sel    = BSEL_IMM;
            ext_mode = EXT_ZERO;
         end
         OP_ORI: begin
            f        = ALU_OR;
            b_sel    = BSEL_IMM;
            ext_mode = EXT_ZERO;
         end
         OP_BEQ: begin
            f      = ALU_SUB;
            is_beq = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- sequencer that feeds one instruction at a time to an external
// 32-bit ALU and returns its result through a valid/ready handshake.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid/in_ready         : instruction handshake (ready only in IDLE)
//   in_opcode..in_imm         : instruction fields and operand values
//   alu_a/alu_b/alu_f         : registered ALU operands and control
//   alu_y/alu_zero            : ALU result and zero flag
//   out_valid/out_ready       : result handshake (valid only in DONE)
//   out_result..out_illegal   : registered result payload
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned ALU_WAIT = 1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [5:0]  in_opcode,
   input  logic [5:0]  in_funct,
   input  logic [31:0] in_rs_val,
   input  logic [31:0] in_rt_val,
   input  logic [15:0] in_imm,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_f,
   input  logic [31:0] alu_y,
   input  logic        alu_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_zero,
   output logic        out_branch_taken,
   output logic        out_illegal
);

   // Counter value on the final EXEC cycle
   localparam logic [3:0] WAIT_LAST = 4'(ALU_WAIT - 1);

   alu_ctl_e    dec_f_s;
   bsel_e       dec_bsel_s;
   ext_e        dec_ext_s;
   logic        dec_beq_s;
   logic        dec_illegal_s;
   logic [31:0] b_next_s;

   state_e      state_r;
   logic [3:0]  cnt_r;
   logic [31:0] alu_a_r;
   logic [31:0] alu_b_r;
   alu_ctl_e    alu_f_r;
   logic        is_beq_r;
   logic        in_ready_r;
   logic        out_valid_r;
   logic [31:0] out_result_r;
   logic        out_zero_r;
   logic        out_branch_r;
   logic        out_illegal_r;

   alu_seq_decode u_decode (
      .opcode   (in_opcode),
      .funct    (in_funct),
      .f        (dec_f_s),
      .b_sel    (dec_bsel_s),
      .ext_mode (dec_ext_s),
      .is_beq   (dec_beq_s),
      .illegal  (dec_illegal_s)
   );

   // Operand B candidate for the instruction currently presented
   always_comb begin
      b_next_s = 32'h0000_0000;
      if (dec_bsel_s == BSEL_IMM) begin
         b_next_s = extend_imm(in_imm, dec_ext_s);
      end else begin
         b_next_s = in_rt_val;
      end
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         cnt_r         <= 4'd0;
         alu_a_r       <= 32'h0000_0000;
         alu_b_r       <= 32'h0000_0000;
         alu_f_r       <= ALU_AND;
         is_beq_r      <= 1'b0;
         in_ready_r    <= 1'b1;
         out_valid_r   <= 1'b0;
         out_result_r  <= 32'h0000_0000;
         out_zero_r    <= 1'b0;
         out_branch_r  <= 1'b0;
         out_illegal_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  in_ready_r <= 1'b0;
                  if (dec_illegal_s) begin
                     // Illegal: payload is known now, the ALU is never driven
                     state_r       <= ST_DONE;
                     out_result_r  <= 32'h0000_0000;
                     out_zero_r    <= 1'b0;
                     out_branch_r  <= 1'b0;
                     out_illegal_r <= 1'b1;
                  end else begin
                     state_r  <= ST_EXEC;
                     cnt_r    <= 4'd0;
                     alu_a_r  <= in_rs_val;
                     alu_b_r  <= b_next_s;
                     alu_f_r  <= dec_f_s;
                     is_beq_r <= dec_beq_s;
                  end
               end
            end
            ST_EXEC: begin
               if (cnt_r == WAIT_LAST) begin
                  out_result_r  <= alu_y;
                  out_zero_r    <= alu_zero;
                  out_branch_r  <= is_beq_r & alu_zero;
                  out_illegal_r <= 1'b0;
                  out_valid_r   <= 1'b1;
                  state_r       <= ST_DONE;
                  cnt_r         <= 4'd0;
                  alu_a_r       <= 32'h0000_0000;
                  alu_b_r       <= 32'h0000_0000;
                  alu_f_r       <= ALU_AND;
                  is_beq_r      <= 1'b0;
               end else begin
                  cnt_r <= cnt_r + 4'd1;
               end
            end
            ST_DONE: begin
               // An illegal instruction enters DONE without out_valid and
               // presents it one cycle later, giving it a one-cycle latency.
               if (!out_valid_r) begin
                  out_valid_r <= 1'b1;
               end else if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cnt_r       <= 4'd0;
               alu_a_r     <= 32'h0000_0000;
               alu_b_r     <= 32'h0000_0000;
               alu_f_r     <= ALU_AND;
               is_beq_r    <= 1'b0;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready         = in_ready_r;
   assign alu_a            = alu_a_r;
   assign alu_b            = alu_b_r;
   assign alu_f            = alu_f_r;
   assign out_valid        = out_valid_r;
   assign out_result       = out_result_r;
   assign out_zero         = out_zero_r;
   assign out_branch_taken = out_branch_r;
   assign out_illegal      = out_illegal_r;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter ALU_WAIT, default 1, meaning EXEC cycles before sampling ALU result (legal range 1..15).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_valid input 1 and in_ready output 1, the instruction handshake.
REQ-005 SHALL have ports in_opcode input 6, in_funct input 6, in_rs_val input 32, in_rt_val input 32 and in_imm input 16, the instruction fields and operand values.
REQ-006 SHALL have ports alu_a output 32, alu_b output 32 and alu_f output 3, which drive the 32-bit ALU.
REQ-007 SHALL have ports alu_y input 32 and alu_zero input 1, the ALU result and zero flag.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the result handshake.
REQ-009 SHALL have ports out_result output 32, out_zero output 1, out_branch_taken output 1 and out_illegal output 1, the result payload.

Function
REQ-010 SHALL implement FSM states IDLE, EXEC and DONE; in_ready is 1 only in IDLE; out_valid is 1 only in DONE.
REQ-011 SHALL, in IDLE with in_valid=1, capture all in_* fields and go to EXEC, or go straight to DONE if the instruction is illegal.
REQ-012 SHALL decode R-type (opcode 000000) by funct: 100000 -> F=010 (add), 100010 -> 110 (sub), 100100 -> 000 (and), 100101 -> 001 (or), 101010 -> 111 (slt); A=rs, B=rt.
REQ-013 SHALL decode I-type opcodes: 001000 addi (F=010) and 001010 slti (F=111) with B=sign-extended imm; 001100 andi (F=000) and 001101 ori (F=001) with B=zero-extended imm; 000100 beq (F=110) with B=rt. A=rs for all.
REQ-014 SHALL treat any other opcode, or any other funct under opcode 000000, as illegal: out_illegal=1, out_result=0, out_zero=0, out_branch_taken=0, EXEC skipped.
REQ-015 SHALL drive alu_a, alu_b and alu_f from registers held constant for the whole of EXEC, and drive them to 0 in IDLE and DONE.
REQ-016 SHALL count ALU_WAIT cycles in EXEC and, on the last EXEC edge, register alu_y into out_result and alu_zero into out_zero, then enter DONE.
REQ-017 SHALL set out_branch_taken = alu_zero for beq and 0 for all other instructions.
REQ-018 SHALL have a latency of ALU_WAIT cycles for a legal instruction and 1 cycle for an illegal one: with acceptance on edge E0, out_valid rises after edge E0+ALU_WAIT or E0+1 respectively.
REQ-019 SHALL hold out_valid and all out_* payload stable in DONE until out_valid and out_ready are both 1 on an edge, then return to IDLE.
REQ-020 SHALL NOT accept a new instruction on the same edge a result is consumed, so in_ready rises one cycle after the handshake.
REQ-021 SHALL ignore in_* changes during EXEC and DONE.

Reset
REQ-022 SHALL, while rst_n=0, immediately force state=IDLE, the wait counter to 0, and alu_a, alu_b, alu_f and all out_* registers to 0; out_valid=0.
REQ-023 SHALL abandon any in-flight instruction when reset asserts mid-EXEC or mid-DONE and produce no result for it.
REQ-024 SHALL have in_ready=1 on the first cycle after rst_n deasserts.

Structure
REQ-025 SHALL place the opcode and funct constants, the ALU control enum (AND=000, OR=001, ADD=010, SUB=110, SLT=111) and the FSM state enum in package alu_seq_pkg.
REQ-026 SHALL implement decode as combinational sub-module alu_seq_decode, which produces F, B-select, extension mode, is_beq and illegal.
REQ-027 SHALL NOT instantiate the ALU internally; it connects externally via the alu_* ports.

Verification
REQ-028 SHALL test add with rs=5, rt=7, ALU model alu_y=12, ALU_WAIT=1 -> alu_f=010, out_result=12, out_zero=0, out_valid 1 cycle after accept.
REQ-029 SHALL test beq with rs=rt=0x00001234 and model alu_zero=1 -> alu_f=110, alu_b=0x00001234, out_branch_taken=1.
REQ-030 SHALL test immediate extension: addi imm=0xFFFF -> alu_b=0xFFFFFFFF; ori imm=0x8000 -> alu_b=0x00008000.
REQ-031 SHALL test illegal opcode 111111 -> out_illegal=1, out_result=0, alu_f stays 000, out_valid 1 cycle after accept.
REQ-032 SHALL test backpressure with out_ready=0 for 5 cycles -> payload stable, in_ready=0, and a presented instruction is not accepted until 1 cycle after the handshake.
REQ-033 SHALL test reset with rst_n=0 mid-EXEC at ALU_WAIT=4 -> out_valid=0, alu_* = 0 at once, no result emitted, in_ready=1 after release.
